softmax_serializer: RTL

SOFTMAX_SERIALIZER -- requirements
Module: softmax_serializer

---
 rtl/softmax_serializer_if.sv | 29 ++
 rtl/softmax_serializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/softmax_serializer_if.sv
// softmax_serializer_if
//   Handshake bundle between the softmax vector producer, the serializer and
//   the downstream lane consumer.
//   vec_in / vec_in_valid / vec_ready : vector side (producer -> serializer)
//   y_out / y_valid / y_last / y_ready : lane side (serializer -> consumer)
//   modport slave  : serializer view
//   modport master : environment view (producer + consumer)
interface softmax_serializer_if #(
  parameter int N = 64,
  parameter int W = 16
);
  logic [N*W-1:0] vec_in;
  logic           vec_in_valid;
  logic           vec_ready;
  logic [W-1:0]   y_out;
  logic           y_valid;
  logic           y_last;
  logic           y_ready;

  modport slave (
    input  vec_in, vec_in_valid, y_ready,
    output vec_ready, y_out, y_valid, y_last
  );

  modport master (
    output vec_in, vec_in_valid, y_ready,
    input  vec_ready, y_out, y_valid, y_last
  );
endinterface

// File: rtl/softmax_serializer.sv
// softmax_serializer
//   Captures an N-lane FP16 probability vector and emits it one lane per beat,
//   lane 0 first, with a valid/ready handshake. Lane data passes bit-exact.
//   Ports:
//     clk  : clock, all state on rising edge
//     rst  : synchronous, active-high reset
//     bus  : softmax_serializer_if.slave (vector in, lane stream out)
//     busy : a vector is active or pending
//   Optional feature: define SOFTMAX_SERIALIZER_SKID_EN to add a pending
//   vector buffer, giving back-to-back vectors with no idle bubble.
module softmax_serializer #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  softmax_serializer_if.slave   bus,
  output logic                  busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [N*W-1:0] active;
  logic           y_valid_q;
  logic           y_last_q;
  logic           accept;
  logic           xfer;
  logic           final_xfer;

`ifdef SOFTMAX_SERIALIZER_SKID_EN
  logic [N*W-1:0] pend;
  logic           pend_valid;

  assign bus.vec_ready = !pend_valid && !rst;
  assign busy          = (state == SEND) || pend_valid;
`else
  assign bus.vec_ready = (state == IDLE) && !rst;
  assign busy          = (state == SEND);
`endif

  assign accept     = bus.vec_in_valid && bus.vec_ready;
  assign xfer       = y_valid_q && bus.y_ready;
  assign final_xfer = xfer && (idx == LAST);

  // The active buffer shifts down one lane per beat, so lane idx always sits
  // in the low W bits and y_out comes straight from flops.
  assign bus.y_out   = active[W-1:0];
  assign bus.y_valid = y_valid_q;
  assign bus.y_last  = y_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      active    <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
`ifdef SOFTMAX_SERIALIZER_SKID_EN
      pend       <= '0;
      pend_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            active    <= bus.vec_in;
            idx       <= '0;
            y_valid_q <= 1'b1;
            y_last_q  <= (N == 1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx == LAST) begin
`ifdef SOFTMAX_SERIALIZER_SKID_EN
              if (pend_valid) begin
                active     <= pend;
                pend_valid <= 1'b0;
                idx        <= '0;
                y_last_q   <= (N == 1);
              end else if (accept) begin
                active   <= bus.vec_in;
                idx      <= '0;
                y_last_q <= (N == 1);
              end else begin
                active    <= '0;
                idx       <= '0;
                y_valid_q <= 1'b0;
                y_last_q  <= 1'b0;
                state     <= IDLE;
              end
`else
              active    <= '0;
              idx       <= '0;
              y_valid_q <= 1'b0;
              y_last_q  <= 1'b0;
              state     <= IDLE;
`endif
            end else begin
              active   <= active >> W;
              idx      <= idx + 1'b1;
              y_last_q <= ((idx + 1'b1) == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef SOFTMAX_SERIALIZER_SKID_EN
      // A vector arriving on the final beat goes straight to the active
      // buffer above; any other accept during SEND parks in pending.
      if (state == SEND && accept && !final_xfer) begin
        pend       <= bus.vec_in;
        pend_valid <= 1'b1;
      end
`endif
    end
  end

endmodule
